// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller slice: default widths, config
// register map and the Q-format unit constant.
package pid_pkg;

  localparam int unsigned D_WIDTH   = 18;  // command / config data width
  localparam int unsigned Q_BITS    = 15;  // fractional bits of the command
  localparam int unsigned CNT_WIDTH = 12;  // PWM period counter width

  // Config register map
  localparam int unsigned ADDR_PERIOD   = 0;
  localparam int unsigned ADDR_DEADTIME = 1;
  localparam int unsigned ADDR_CTRL     = 2;

  // 1.0 in the command's Q format
  localparam int ONE = 1 <<< Q_BITS;

endpackage

// File: rtl/pid_pwm_out_if.sv
// Config bus and command stream into the PWM output stage.
//   write_enable : active-low config write strobe
//   reg_addr     : config address (period / dead-time / control)
//   reg_data     : config write data, low bits used
//   cmd          : signed Q-format command from the PID core
//   cmd_valid    : cmd is new this cycle
// master drives the bus, slave (the PWM stage) consumes it.
interface pid_pwm_out_if
  import pid_pkg::*;
#(
  parameter int unsigned W = D_WIDTH
);

  logic                write_enable;
  logic [W-1:0]        reg_addr;
  logic [W-1:0]        reg_data;
  logic signed [W-1:0] cmd;
  logic                cmd_valid;

  modport master (output write_enable, reg_addr, reg_data, cmd, cmd_valid);
  modport slave  (input  write_enable, reg_addr, reg_data, cmd, cmd_valid);

endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for a complementary half-bridge gate pair.
//   clock, reset : clock, async active-low reset
//   en           : stage enabled; when low both gates are forced off and the
//                  dead-time count is held loaded
//   raw          : un-delayed PWM level
//   dt           : dead-time in clocks
//   pwm_hi/lo    : registered gate drives, never high together
module pwm_deadtime #(
  parameter int unsigned CNT_WIDTH = pid_pkg::CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 raw,
  input  logic [CNT_WIDTH-1:0] dt,
  output logic                 pwm_hi,
  output logic                 pwm_lo
);

  logic                 raw_prev_q, raw_prev_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                 hi_q, hi_d;
  logic                 lo_q, lo_d;

  // Reload on every raw edge (and on the first enabled cycle), count down to 0;
  // a gate may only turn on once the count has expired.
  always_comb begin
    raw_prev_d = raw;
    first_d    = !en;
    dcnt_d     = dcnt_q;
    hi_d       = 1'b0;
    lo_d       = 1'b0;
    if (!en) begin
      dcnt_d = dt;
    end else begin
      if (first_q || (raw != raw_prev_q)) begin
        dcnt_d = dt;
      end else if (dcnt_q != '0) begin
        dcnt_d = dcnt_q - CNT_WIDTH'(1);
      end
      // Using the next count lets a dead-time of 0 pass raw straight through.
      hi_d = raw  && (dcnt_d == '0);
      lo_d = !raw && (dcnt_d == '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raw_prev_q <= 1'b0;
      first_q    <= 1'b1;
      dcnt_q     <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
    end else begin
      raw_prev_q <= raw_prev_d;
      first_q    <= first_d;
      dcnt_q     <= dcnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pid_pwm_out.sv
// PID output stage: turns the signed Q-format command into a complementary
// PWM pair with programmable period and dead-time, and paces the controller
// with one iterate_enable tick per PWM period.
//   clock, reset    : clock, async active-low reset
//   bus (slave)     : config writes and command stream
//   iterate_enable  : one-cycle tick when the counter is 0 and running
//   pwm_hi, pwm_lo  : high / low side gate drives
//   sat             : last captured command was clamped to +/-1.0
module pid_pwm_out #(
  parameter int unsigned D_WIDTH    = pid_pkg::D_WIDTH,
  parameter int unsigned Q_BITS     = pid_pkg::Q_BITS,
  parameter int unsigned CNT_WIDTH  = pid_pkg::CNT_WIDTH,
  parameter int unsigned PERIOD_RST = 1000,
  parameter int unsigned DT_RST     = 8
) (
  input  logic          clock,
  input  logic          reset,
  pid_pwm_out_if.slave  bus,
  output logic          iterate_enable,
  output logic          pwm_hi,
  output logic          pwm_lo,
  output logic          sat
);

  import pid_pkg::*;

  localparam int unsigned OFF_W  = Q_BITS + 2;
  localparam int unsigned PROD_W = Q_BITS + 2 + CNT_WIDTH;

  localparam logic signed [D_WIDTH-1:0] POS_ONE = D_WIDTH'(1 <<< Q_BITS);
  localparam logic signed [D_WIDTH-1:0] NEG_ONE = -POS_ONE;

  localparam logic [CNT_WIDTH-1:0] PERIOD_INIT = CNT_WIDTH'(PERIOD_RST);
  localparam logic [CNT_WIDTH-1:0] DT_INIT     = CNT_WIDTH'(DT_RST);
  localparam logic [CNT_WIDTH-1:0] DUTY_INIT   = CNT_WIDTH'(PERIOD_RST / 2);

  logic [CNT_WIDTH-1:0] period_sh_q, period_sh_d;
  logic [CNT_WIDTH-1:0] period_q,    period_d;
  logic [CNT_WIDTH-1:0] dt_sh_q,     dt_sh_d;
  logic [CNT_WIDTH-1:0] dt_q,        dt_d;
  logic                 run_q,       run_d;
  logic [CNT_WIDTH-1:0] cnt_q,       cnt_d;
  logic [CNT_WIDTH-1:0] pend_q,      pend_d;
  logic [CNT_WIDTH-1:0] act_q,       act_d;
  logic                 sat_q,       sat_d;
  logic                 iter_q,      iter_d;

  logic [CNT_WIDTH-1:0]      wdata;
  logic signed [D_WIDTH-1:0] clamped;
  logic                      clamp_hit;
  logic [OFF_W-1:0]          offset;
  logic [PROD_W-1:0]         prod;
  logic [CNT_WIDTH-1:0]      duty_new;
  logic                      wrap;
  logic                      raw;
  logic                      gate_en;

  // Upper config data bits carry no information.
  logic unused_data_hi;
  assign unused_data_hi = ^bus.reg_data[D_WIDTH-1:CNT_WIDTH];

  // Config writes into the shadow registers.
  always_comb begin
    wdata       = CNT_WIDTH'(bus.reg_data);
    period_sh_d = period_sh_q;
    dt_sh_d     = dt_sh_q;
    run_d       = run_q;
    if (!bus.write_enable) begin
      case (bus.reg_addr)
        D_WIDTH'(ADDR_PERIOD):   period_sh_d = (wdata < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : wdata;
        D_WIDTH'(ADDR_DEADTIME): dt_sh_d     = wdata;
        D_WIDTH'(ADDR_CTRL):     run_d       = bus.reg_data[0];
        default: ;
      endcase
    end
  end

  // Clamp the command and scale [-1,+1] onto 0..period of the shadow period.
  always_comb begin
    clamped   = bus.cmd;
    clamp_hit = 1'b0;
    if (bus.cmd > POS_ONE) begin
      clamped   = POS_ONE;
      clamp_hit = 1'b1;
    end else if (bus.cmd < NEG_ONE) begin
      clamped   = NEG_ONE;
      clamp_hit = 1'b1;
    end
    offset   = OFF_W'(clamped + POS_ONE);
    prod     = PROD_W'(offset) * PROD_W'(period_sh_q);
    duty_new = CNT_WIDTH'(prod >> (Q_BITS + 1));

    pend_d = pend_q;
    sat_d  = sat_q;
    if (bus.cmd_valid) begin
      pend_d = duty_new;
      sat_d  = clamp_hit;
    end
  end

  // Period counter, active-register load at the wrap, tick generation.
  // While stopped the active copies track pending/shadow so a fresh start
  // uses the latest configuration from its first cycle.
  always_comb begin
    wrap     = run_q && (cnt_q == period_q - CNT_WIDTH'(1));
    period_d = period_q;
    dt_d     = dt_q;
    act_d    = act_q;
    if (!run_q || wrap) begin
      period_d = period_sh_q;
      dt_d     = dt_sh_q;
      act_d    = pend_q;
    end
    if (!run_q || !run_d || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    iter_d = run_d && (cnt_d == '0);
  end

  assign raw = run_q && (cnt_q < act_q);
  // Dropping run forces both gates off on the very next edge.
  assign gate_en = run_q && run_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_sh_q <= PERIOD_INIT;
      period_q    <= PERIOD_INIT;
      dt_sh_q     <= DT_INIT;
      dt_q        <= DT_INIT;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= DUTY_INIT;
      act_q       <= DUTY_INIT;
      sat_q       <= 1'b0;
      iter_q      <= 1'b0;
    end else begin
      period_sh_q <= period_sh_d;
      period_q    <= period_d;
      dt_sh_q     <= dt_sh_d;
      dt_q        <= dt_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      sat_q       <= sat_d;
      iter_q      <= iter_d;
    end
  end

  pwm_deadtime #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_deadtime (
    .clock  (clock),
    .reset  (reset),
    .en     (gate_en),
    .raw    (raw),
    .dt     (dt_q),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

  assign iterate_enable = iter_q;
  assign sat            = sat_q;

endmodule

// File: doc/pid_pwm_out.md
Name: pid_pwm_out

Overview:
- Downstream stage of the PID controller: converts its signed fixed-point command (value in [-1.0, +1.0]) into a complementary half-bridge PWM pair with programmable period and dead-time.
- Generates the periodic iterate_enable tick that paces the controller, so one control update occurs per PWM period.
- Double-buffers the command so duty changes only at period boundaries.

Parameters:
- D_WIDTH, 18, command/config data width.
- Q_BITS, 15, fractional bits of the command; 1.0 = 2^Q_BITS.
- CNT_WIDTH, 12, period counter width.
- PERIOD_RST, 1000, period register reset value in clocks.
- DT_RST, 8, dead-time register reset value in clocks.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- write_enable, input, 1, active-low config write strobe.
- reg_addr, input, D_WIDTH, config address: 0 = period, 1 = dead-time, 2 = control (bit0 = run).
- reg_data, input, D_WIDTH, config data; low bits used.
- cmd, input, D_WIDTH signed, PID output (out_clocked).
- cmd_valid, input, 1, cmd is new this cycle.
- iterate_enable, output, 1, one-cycle tick at each period start.
- pwm_hi, output, 1, high-side gate.
- pwm_lo, output, 1, low-side gate.
- sat, output, 1, last captured cmd was clamped.

Behaviour:
- Interface: reset is asynchronous, active-low, named reset; clock is named clock.
- Reset values:
  - Outputs: pwm_hi = pwm_lo = 0, iterate_enable = 0, sat = 0.
  - State: counter = 0, period = PERIOD_RST, dead-time = DT_RST, run = 0.
  - Duty: pending = active = PERIOD_RST/2.
- Reset mid-period: everything returns to the values above immediately (asynchronous).
- Config writes:
  - Applied on any clock where write_enable = 0; unknown addresses are ignored.
  - A written period < 2 is stored as 2.
  - Period and dead-time writes land in shadow registers, copied to active at the next wrap (immediately while run = 0).
- Counter:
  - Counts 0 .. active_period-1, then wraps to 0.
  - iterate_enable = 1 on exactly the cycles where the counter is 0 and run = 1.
- Command capture:
  - On cmd_valid, clamp cmd to [-2^Q_BITS, +2^Q_BITS] and register sat.
  - duty = ((clamped + 2^Q_BITS) * shadow_period) >> (Q_BITS+1), unsigned, range 0 .. period.
  - Intermediate width: Q_BITS+2+CNT_WIDTH bits; truncation, no rounding.
  - The result is registered into pending one cycle after cmd_valid.
- Active load: on the wrap cycle (counter = period-1), active_duty <= pending as it stood before that cycle. A pending update arriving in the same cycle applies to the following period (no bypass).
- Raw PWM: raw = (counter < active_duty). duty 0 means raw is always 0; duty = period means raw is always 1.
- Dead-time:
  - A down-counter reloads to the dead-time value on every raw edge.
  - pwm_hi = raw and count expired; pwm_lo = !raw and count expired.
  - Pulses shorter than dead-time are swallowed: both outputs stay low for that interval.
  - Dead-time 0 gives pwm_hi = raw and pwm_lo = !raw.
  - pwm_hi and pwm_lo are never 1 together (hard invariant).
  - Outputs are registered: one cycle latency from raw.
- Run control:
  - run 0 -> 1: counter starts at 0, tick fires that cycle, dead-time count starts loaded (both outputs low for the first dead-time cycles).
  - run 1 -> 0: both outputs low on the next cycle, counter held at 0, no ticks.

Decomposition:
- Shared package pid_pkg holds:
  - D_WIDTH, Q_BITS, CNT_WIDTH defaults.
  - Config address constants (ADDR_PERIOD, ADDR_DEADTIME, ADDR_CTRL).
  - Q-format ONE constant (1 <<< Q_BITS).
- One sub-module, pwm_deadtime: takes raw and dead-time in, drives the registered pwm_hi/pwm_lo with the dead-time counter.

Test Plan:
- Period 100, dead-time 0, run 1, cmd 0 -> duty 50; pwm_hi high counter 0–49, pwm_lo high 50–99 (+1 cycle latency); iterate_enable every 100 clocks.
- cmd +32768 then -32768 (and +40000) -> duty 100 (pwm_hi constant) then 0 (pwm_lo constant); sat = 1 only for +40000.
- Dead-time 5, cmd 0 -> pwm_hi high counter 5–49, pwm_lo high 55–99; never both high; cmd -32440 (duty 0.5 clk... 0) pulse < 5 fully suppressed.
- cmd_valid asserted on the wrap cycle with new cmd +16384 -> duty 75 takes effect one period later, not the immediate one.
- Period write 50 mid-period -> current period finishes at 100, next wrap at 50; period write 1 -> reads as 2, ticks every 2 clocks.
- reset low mid-period, then run cleared -> outputs 0 immediately; after run set, first tick the same cycle; registers back to PERIOD_RST/DT_RST.
